timer_arbiter: RTL and testbench
================================

# timer_arbiter

Shares one seconds-resolution delay timer among `NREQ` requesting FSMs. Each requester asks for a delay of N seconds; the block grants requesters one at a time in round-robin order, runs the delay, and returns a one-cycle completion pulse to the owner. It sits between the control FSMs and the single timing resource on the 10 kHz system clock, so no requester instantiates its own prescaler.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `CLK_HZ`, 10000, clock cycles per second (prescaler terminal count is `CLK_HZ-1`)
- `SEC_W`, 7, width of a seconds value
- `CLK` in 1: system clock, rising edge
- `RST_N` in 1: reset, asynchronous, active-low
- `req` in `NREQ`: per-requester request level; held until `grant[i]`
- `req_secs` in `NREQ*SEC_W`: requester i's delay in seconds at bits `[i*SEC_W +: SEC_W]`; must be stable while `req[i]`=1
- `grant` out `NREQ`: one-hot, one-cycle pulse; request accepted, seconds latched
- `done` out `NREQ`: one-hot, one-cycle pulse; owner's delay elapsed
- `busy` out 1: high in LOAD, COUNT and DONE
- `owner` out `$clog2(NREQ)`: index of the current or last owner
- `secs_left` out `SEC_W`: whole seconds remaining; 0 when idle

## Operation
- Reset: state IDLE; `grant`, `done`, `busy`, `owner`, `secs_left` = 0; round-robin pointer = 0; prescaler and seconds counter = 0. These apply immediately on the `RST_N` fall, including in the middle of a delay. The aborted owner gets no `done`.
- FSM states: IDLE, LOAD, COUNT, DONE.
- IDLE: if any `req` bit is set, select the first set bit at or after the pointer, wrapping modulo `NREQ`. Record it in `owner` and go to LOAD. Otherwise stay in IDLE.
- LOAD (1 cycle): pulse `grant[owner]`. Latch `req_secs[owner]` into the target. Clear the prescaler and seconds counter. Set `secs_left` = target. If target = 0, go to DONE; otherwise go to COUNT.
- COUNT: the prescaler counts 0..`CLK_HZ-1` and wraps. At each wrap, `secs_left` decrements. The wrap that takes `secs_left` from 1 to 0 moves the FSM to DONE.
- DONE (1 cycle): pulse `done[owner]`. Set the pointer to `owner+1` (mod `NREQ`). Go to IDLE.
- Requests are only sampled in IDLE. Requests that arrive during LOAD, COUNT or DONE wait.
- A requester may re-raise `req` in the cycle `done` is seen. It then competes normally, and round-robin places it last.
- Counter widths: the prescaler is `$clog2(CLK_HZ)` bits. The target and `secs_left` are `SEC_W` bits, with no overflow possible. The maximum delay is `2^SEC_W-1` seconds.

## Timing
- `req[i]` rising while idle → `grant[i]` high 2 cycles later (IDLE sample, then LOAD).
- `grant` → `done`: exactly `secs*CLK_HZ + 1` cycles for `secs` ≥ 1; 1 cycle for `secs` = 0.
- Back-to-back: after DONE, the next `grant` comes 2 cycles later (IDLE, LOAD).
- `grant` and `done` are never high in the same cycle, and never for more than one cycle.
- `secs_left` updates in the same cycle as the prescaler wrap.

## Configuration
- `TIMER_ARBITER_ABORT_EN` defined:
  - Adds input `abort`, width `NREQ`.
  - `abort[owner]` sampled high in COUNT returns the FSM to IDLE on the next edge. It clears the counters and `secs_left`, sets the pointer to `owner+1`, and issues no `done`.
  - `abort` on non-owners, or in other states, is ignored.
- Not defined: the `abort` port does not exist, and every granted delay runs to `done`.

## Structure
- Package `timer_arbiter_pkg`: state enum (IDLE, LOAD, COUNT, DONE), default `CLK_HZ` = 10000, default `SEC_W` = 7.
- Sub-module `sec_tick_counter`: prescaler plus `secs_left` down-counter.
  - Inputs: `load`, `load_val`, `clr`.
  - Outputs: `secs_left`, `expire` (one-cycle pulse on the 1→0 wrap).
- The top level holds the FSM, the round-robin pointer, the request mux and the one-hot decode of `grant`/`done`.

## Test plan
Benches use `CLK_HZ`=10, `NREQ`=4, `SEC_W`=7.
- Single request: `req[2]`=1 with secs=3 → `grant[2]` 2 cycles later, `done[2]` 31 cycles after grant, `busy` low 1 cycle after done.
- Zero delay: `req[0]` with secs=0 → `done[0]` 1 cycle after `grant[0]`; `secs_left` stays 0.
- Fairness: `req` = 4'b1111 held, each with secs=1 → grants in order 0, 1, 2, 3, 0; consecutive grants 13 cycles apart.
- Late arrival: `req[3]` rises while requester 1 is in COUNT → `req[3]` not granted until 2 cycles after `done[1]`.
- Reset mid-delay: `RST_N` low during COUNT with `secs_left`=2 → all outputs 0 immediately; no `done`; after release, a new `req[1]` is granted first from pointer 0.
- With `TIMER_ARBITER_ABORT_EN`: `abort[owner]` during COUNT → IDLE next cycle, no `done`, next pending requester granted 2 cycles later; `abort` on a non-owner has no effect.

Source files
------------

// File: rtl/timer_arbiter_pkg.sv
// Shared state encoding, default parameters and round-robin helper for timer_arbiter.
package timer_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COUNT,
    DONE
  } state_t;

  localparam int unsigned DEFAULT_CLK_HZ = 10000;
  localparam int unsigned DEFAULT_SEC_W  = 7;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sec_tick_counter.sv
// Seconds prescaler plus secs_left down-counter; expire pulses combinationally on the 1->0 wrap.
module sec_tick_counter #(
  parameter int unsigned CLK_HZ = 10000,
  parameter int unsigned SEC_W  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SEC_W-1:0] load_val,
  input  logic             clr,
  output logic [SEC_W-1:0] secs_left,
  output logic             expire
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;
  logic          running;
  logic          wrap;

  // A non-zero secs_left is the only state in which the prescaler runs.
  assign running = (secs_left != '0);
  assign wrap    = running && (presc == PRESC_MAX);
  assign expire  = wrap && (secs_left == SEC_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      secs_left <= '0;
    end else if (load || clr) begin
      presc     <= '0;
      secs_left <= load ? load_val : '0;
    end else if (running) begin
      if (wrap) begin
        presc     <= '0;
        secs_left <= secs_left - 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one seconds timer among NREQ requesters.
// Optional TIMER_ARBITER_ABORT_EN adds a per-requester abort input.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
  parameter int unsigned SEC_W  = DEFAULT_SEC_W
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*SEC_W-1:0]    req_secs,
`ifdef TIMER_ARBITER_ABORT_EN
  input  logic [NREQ-1:0]          abort,
`endif
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic [SEC_W-1:0]         secs_left
);

  localparam int unsigned OW = $clog2(NREQ);

  state_t          state, state_next;
  logic [OW-1:0]   ptr;
  logic [OW-1:0]   pick;
  logic            pick_vld;
  logic [SEC_W-1:0] load_val;
  logic            load;
  logic            clr;
  logic            expire;
  logic            abort_hit;
  logic [NREQ-1:0] owner_hot;

  assign owner_hot = NREQ'(1) << owner;

`ifdef TIMER_ARBITER_ABORT_EN
  assign abort_hit = abort[owner];
`else
  assign abort_hit = 1'b0;
`endif

  // First set request at or after ptr, wrapping modulo NREQ.
  always_comb begin : rr_pick
    int unsigned idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!pick_vld && req[OW'(idx)]) begin
        pick     = OW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    load_val = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner == OW'(i)) load_val = req_secs[i*SEC_W +: SEC_W];
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    clr        = 1'b0;
    case (state)
      IDLE:  if (pick_vld) state_next = LOAD;
      LOAD: begin
        load       = 1'b1;
        state_next = (load_val == '0) ? DONE : COUNT;
      end
      COUNT: begin
        if (abort_hit) begin
          clr        = 1'b1;
          state_next = IDLE;
        end else if (expire) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so grant/done/busy lag it by one cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      grant <= '0;
      done  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && pick_vld) owner <= pick;
      if (state == DONE || (state == COUNT && abort_hit)) ptr <= OW'(rr_next(32'(owner), NREQ));
      grant <= (state == LOAD) ? owner_hot : '0;
      done  <= (state == DONE) ? owner_hot : '0;
      busy  <= (state != IDLE);
    end
  end

  sec_tick_counter #(
    .CLK_HZ (CLK_HZ),
    .SEC_W  (SEC_W)
  ) u_tick (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load      (load),
    .load_val  (load_val),
    .clr       (clr),
    .secs_left (secs_left),
    .expire    (expire)
  );

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed self-checking bench for timer_arbiter with CLK_HZ=10, NREQ=4, SEC_W=7.
module tb_timer_arbiter;

  logic        CLK;
  logic        RST_N;
  logic [3:0]  req;
  logic [27:0] req_secs;
`ifdef TIMER_ARBITER_ABORT_EN
  logic [3:0]  abort;
`endif
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  owner;
  logic [6:0]  secs_left;

  int checks   = 0;
  int failures = 0;

  timer_arbiter #(
    .NREQ   (4),
    .CLK_HZ (10),
    .SEC_W  (7)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req       (req),
    .req_secs  (req_secs),
`ifdef TIMER_ARBITER_ABORT_EN
    .abort     (abort),
`endif
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .owner     (owner),
    .secs_left (secs_left)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (done === 4'b0000 && n < max);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 300) begin
      tick();
      t++;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    req = '0;
    req_secs = '0;
`ifdef TIMER_ARBITER_ABORT_EN
    abort = '0;
`endif
    tick(); tick();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done: got %b want 0000", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner: got %0d want 0", owner); end
    checks++; if (secs_left !== 7'd0) begin failures++; $display("FAIL reset_secs: got %0d want 0", secs_left); end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_fairness();
    logic [3:0] gval [5];
    int gcyc [5];
    int ng, t, overlap;
    ng = 0; t = 0; overlap = 0;
    req_secs = {4{7'd1}};
    req = 4'b1111;
    while (ng < 5 && t < 200) begin
      tick();
      t++;
      if (grant !== 4'b0000 && done !== 4'b0000) overlap++;
      if (grant !== 4'b0000) begin
        gval[ng] = grant;
        gcyc[ng] = t;
        ng++;
      end
    end
    req = 4'b0000;
    checks++; if (ng !== 5) begin failures++; $display("FAIL fair_count: got %0d want 5", ng); end
    checks++; if (overlap !== 0) begin failures++; $display("FAIL fair_overlap: got %0d want 0", overlap); end
    if (ng == 5) begin
      checks++; if (gcyc[0] !== 2) begin failures++; $display("FAIL fair_first_latency: got %0d want 2", gcyc[0]); end
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (gval[k] !== (4'b0001 << (k % 4))) begin
          failures++; $display("FAIL fair_order[%0d]: got %b want %b", k, gval[k], 4'b0001 << (k % 4));
        end
        if (k > 0) begin
          checks++;
          if (gcyc[k] - gcyc[k-1] !== 13) begin
            failures++; $display("FAIL fair_spacing[%0d]: got %0d want 13", k, gcyc[k] - gcyc[k-1]);
          end
        end
      end
    end
    wait_idle();
  endtask

  task automatic test_single();
    int n;
    logic [6:0] s9, s10;
    s9 = '0; s10 = '0;
    req_secs[2*7 +: 7] = 7'd3;
    req = 4'b0100;
    tick();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL single_early_grant: got %b want 0000", grant); end
    checks++; if (owner !== 2'd2) begin failures++; $display("FAIL single_owner: got %0d want 2", owner); end
    tick();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL single_grant: got %b want 0100", grant); end
    checks++; if (secs_left !== 7'd3) begin failures++; $display("FAIL single_secs_load: got %0d want 3", secs_left); end
    req = 4'b0000;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 9) s9 = secs_left;
      if (n == 10) s10 = secs_left;
    end while (done === 4'b0000 && n < 100);
    checks++; if (n !== 31) begin failures++; $display("FAIL single_latency: got %0d want 31", n); end
    checks++; if (done !== 4'b0100) begin failures++; $display("FAIL single_done: got %b want 0100", done); end
    checks++; if (s9 !== 7'd3) begin failures++; $display("FAIL single_secs_prewrap: got %0d want 3", s9); end
    checks++; if (s10 !== 7'd2) begin failures++; $display("FAIL single_secs_wrap: got %0d want 2", s10); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_at_done: got %b want 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after: got %b want 0", busy); end
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL single_done_width: got %b want 0000", done); end
  endtask

  task automatic test_zero();
    req_secs[0 +: 7] = 7'd0;
    req = 4'b0001;
    tick(); tick();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL zero_grant: got %b want 0001", grant); end
    checks++; if (secs_left !== 7'd0) begin failures++; $display("FAIL zero_secs_grant: got %0d want 0", secs_left); end
    req = 4'b0000;
    tick();
    checks++; if (done !== 4'b0001) begin failures++; $display("FAIL zero_done: got %b want 0001", done); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL zero_grant_width: got %b want 0000", grant); end
    checks++; if (secs_left !== 7'd0) begin failures++; $display("FAIL zero_secs_done: got %0d want 0", secs_left); end
    wait_idle();
  endtask

  task automatic test_late();
    int n, stray;
    req_secs[1*7 +: 7] = 7'd2;
    req_secs[3*7 +: 7] = 7'd1;
    req = 4'b0010;
    tick(); tick();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL late_grant1: got %b want 0010", grant); end
    req = 4'b0000;
    n = 0; stray = 0;
    do begin
      tick();
      n++;
      if (n == 5) req = 4'b1000;
      if (grant !== 4'b0000) stray++;
    end while (done === 4'b0000 && n < 100);
    checks++; if (n !== 21) begin failures++; $display("FAIL late_latency1: got %0d want 21", n); end
    checks++; if (done !== 4'b0010) begin failures++; $display("FAIL late_done1: got %b want 0010", done); end
    checks++; if (stray !== 0) begin failures++; $display("FAIL late_early_grant: got %0d want 0", stray); end
    tick();
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL late_gap: got %b want 0000", grant); end
    tick();
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL late_grant3: got %b want 1000", grant); end
    req = 4'b0000;
    wait_done(100, n);
    checks++; if (n !== 11) begin failures++; $display("FAIL late_latency3: got %0d want 11", n); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int n;
    req_secs[1*7 +: 7] = 7'd0;
    req = 4'b0010;
    tick(); tick();
    req = 4'b0000;
    wait_idle();
    req_secs[2*7 +: 7] = 7'd3;
    req = 4'b0100;
    tick(); tick();
    req = 4'b0000;
    for (int k = 0; k < 10; k++) tick();
    checks++; if (secs_left !== 7'd2) begin failures++; $display("FAIL rstmid_pre_secs: got %0d want 2", secs_left); end
    RST_N = 1'b0;
    #1;
    checks++; if (secs_left !== 7'd0) begin failures++; $display("FAIL rstmid_secs: got %0d want 0", secs_left); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL rstmid_owner: got %0d want 0", owner); end
    tick(); tick();
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL rstmid_done: got %b want 0000", done); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rstmid_grant: got %b want 0000", grant); end
    RST_N = 1'b1;
    req_secs[3*7 +: 7] = 7'd0;
    req = 4'b1010;
    tick(); tick();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL rstmid_ptr: got %b want 0010", grant); end
    req = 4'b1000;
    wait_done(50, n);
    checks++; if (done !== 4'b0010) begin failures++; $display("FAIL rstmid_done1: got %b want 0010", done); end
    tick(); tick();
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL rstmid_grant3: got %b want 1000", grant); end
    req = 4'b0000;
    wait_done(50, n);
    wait_idle();
  endtask

`ifdef TIMER_ARBITER_ABORT_EN
  task automatic test_abort();
    int n;
    req_secs[1*7 +: 7] = 7'd5;
    req_secs[2*7 +: 7] = 7'd1;
    req = 4'b0110;
    tick(); tick();
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL abort_grant1: got %b want 0010", grant); end
    req = 4'b0100;
    tick(); tick();
    abort = 4'b0100;
    tick();
    abort = 4'b0000;
    tick();
    checks++; if (secs_left !== 7'd5) begin failures++; $display("FAIL abort_nonowner_secs: got %0d want 5", secs_left); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_nonowner_busy: got %b want 1", busy); end
    for (int k = 0; k < 8; k++) tick();
    checks++; if (secs_left !== 7'd4) begin failures++; $display("FAIL abort_pre_secs: got %0d want 4", secs_left); end
    abort = 4'b0010;
    tick();
    abort = 4'b0000;
    checks++; if (secs_left !== 7'd0) begin failures++; $display("FAIL abort_secs_clr: got %0d want 0", secs_left); end
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL abort_no_done: got %b want 0000", done); end
    tick();
    checks++; if (grant !== 4'b0000 || done !== 4'b0000) begin failures++; $display("FAIL abort_gap: got grant=%b done=%b want 0000/0000", grant, done); end
    tick();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL abort_next_grant: got %b want 0100", grant); end
    req = 4'b0000;
    wait_done(50, n);
    checks++; if (done !== 4'b0100) begin failures++; $display("FAIL abort_next_done: got %b want 0100", done); end
    checks++; if (n !== 11) begin failures++; $display("FAIL abort_next_latency: got %0d want 11", n); end
    wait_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_zero();
    test_late();
    test_reset_mid();
`ifdef TIMER_ARBITER_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
